// File: rtl/sd_multi_sector_buffer_if.sv
// sd_multi_sector_buffer_if: CPU byte-access bus into the sector-buffer window
// request/write/address/wdata: 1-cycle access strobe from CPU; rdata/data_dv: registered reply next cycle
interface sd_multi_sector_buffer_if #(parameter int ADDR_W = 12);
  logic request;
  logic write;
  logic [ADDR_W-1:0] address;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic data_dv;
  modport master (output request, write, address, wdata, input rdata, data_dv);
  modport slave (input request, write, address, wdata, output rdata, data_dv);
endinterface

// File: rtl/sd_multi_sector_buffer.sv
// sd_multi_sector_buffer: CPU window onto NUM_BUF sector buffers that sequences multi-sector SD transfers
// i_clk/i_rst_n: clock, async active-low reset; bus: CPU access port (reply one cycle after request)
// o_irq/o_busy: DONE&IRQ_EN level interrupt, transfer active; o_sd_*/i_sd_*: controller command and buffer port
module sd_multi_sector_buffer #(
  parameter int SECTOR_AW = 9,
  parameter int NUM_BUF = 4,
  parameter int ADDR_W = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  sd_multi_sector_buffer_if.slave bus,
  output logic                 o_irq,
  output logic                 o_busy,
  output logic [31:0]          o_sd_lba,
  output logic [7:0]           o_sd_cmd,
  input  logic                 i_sd_cmd_done,
  input  logic [7:0]           i_sd_status,
  input  logic [SECTOR_AW-1:0] i_sd_buf_addr,
  input  logic                 i_sd_buf_wr,
  input  logic [7:0]           i_sd_buf_wdata,
  output logic [7:0]           o_sd_buf_rdata
);
  localparam int R = NUM_BUF * (2 ** SECTOR_AW);
  localparam int AW = $clog2(R);
  localparam int BW = NUM_BUF > 1 ? $clog2(NUM_BUF) : 1;
  localparam logic [ADDR_W-1:0] RB = ADDR_W'(R);
  localparam logic [7:0] NB = 8'(NUM_BUF);
  localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2;
  logic [7:0] mem [R];
  logic [1:0] state;
  logic dir, done, err, irq_en;
  logic [31:0] lba, cur_lba;
  logic [7:0] count, rem, eff, reg_rd;
  logic [BW-1:0] first_buf, cur_buf;
  logic [AW-1:0] cpu_a, sd_a;
  logic [2:0] ra;
  logic is_buf, is_reg, cpu_wr, ctl_wr, start, sd_fin;
  assign cpu_a = bus.address[AW-1:0];
  // buffer index sits above the byte index; truncation drops the index bit when NUM_BUF is 1
  assign sd_a = AW'({cur_buf, i_sd_buf_addr});
  assign ra = bus.address[2:0];
  assign is_buf = bus.address < RB;
  assign is_reg = bus.address[ADDR_W-1:3] == RB[ADDR_W-1:3];
  assign cpu_wr = bus.request & bus.write;
  assign ctl_wr = cpu_wr & is_reg & ~o_busy;
  assign eff = count == 8'd0 ? 8'd1 : count;
  assign start = ctl_wr & ra == 3'd4 & (bus.wdata[0] ^ bus.wdata[1]);
  assign sd_fin = state == WAIT & i_sd_cmd_done;
  assign o_busy = state != IDLE;
  assign o_sd_cmd = o_busy ? (dir ? 8'h02 : 8'h01) : 8'h00;
  assign o_sd_lba = cur_lba;
  always_comb begin
    reg_rd = ra == 3'd0 ? lba[7:0] : ra == 3'd1 ? lba[15:8] : ra == 3'd2 ? lba[23:16] :
             ra == 3'd3 ? lba[31:24] : ra == 3'd5 ? count :
             ra == 3'd6 ? {4'b0, irq_en, err, done, o_busy} : ra == 3'd7 ? 8'(first_buf) : 8'h00;
  end
  // controller write wins a same-byte collision; CPU sees pre-write contents
  always_ff @(posedge i_clk) begin
    if (i_sd_buf_wr) mem[sd_a] <= i_sd_buf_wdata;
    if (cpu_wr & is_buf & ~(i_sd_buf_wr & sd_a == cpu_a)) mem[cpu_a] <= bus.wdata;
    o_sd_buf_rdata <= mem[sd_a];
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      dir <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      irq_en <= 1'b0;
      lba <= '0;
      cur_lba <= '0;
      count <= '0;
      rem <= '0;
      first_buf <= '0;
      cur_buf <= '0;
      o_irq <= 1'b0;
      bus.rdata <= '0;
      bus.data_dv <= 1'b0;
    end else begin
      bus.data_dv <= bus.request;
      if (bus.request) bus.rdata <= is_buf ? mem[cpu_a] : is_reg ? reg_rd : 8'h00;
      o_irq <= done & irq_en;
      if (ctl_wr & ~ra[2]) lba[{ra[1:0], 3'b000} +: 8] <= bus.wdata;
      if (ctl_wr & ra == 3'd5) count <= bus.wdata;
      if (ctl_wr & ra == 3'd7) first_buf <= NUM_BUF > 1 ? bus.wdata[BW-1:0] : '0;
      if (cpu_wr & is_reg & ra == 3'd6) begin
        irq_en <= bus.wdata[3];
        if (bus.wdata[1]) begin
          done <= 1'b0;
          err <= 1'b0;
        end
      end
      if (start) begin
        done <= 1'b1;
        err <= 1'b1;
        if (eff <= NB) begin
          state <= ISSUE;
          dir <= bus.wdata[1];
          rem <= eff;
          cur_lba <= lba;
          cur_buf <= first_buf;
          done <= 1'b0;
          err <= 1'b0;
        end
      end
      if (state == ISSUE) state <= WAIT;
      if (sd_fin) begin
        if (i_sd_status != 8'h00) begin
          err <= 1'b1;
          done <= 1'b1;
          state <= IDLE;
        end else if (rem == 8'd1) begin
          done <= 1'b1;
          state <= IDLE;
        end else begin
          rem <= rem - 8'd1;
          cur_lba <= cur_lba + 32'd1;
          cur_buf <= cur_buf + 1'b1;
          state <= ISSUE;
        end
      end
    end
  end
endmodule

// File: tb/tb_sd_multi_sector_buffer.sv
// tb_sd_multi_sector_buffer: scoreboard bench for the multi-sector SD buffer window
module tb_sd_multi_sector_buffer;
  localparam int R = 2048;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  sd_multi_sector_buffer_if #(.ADDR_W(12)) bus();
  logic o_irq, o_busy, sd_done, sd_wr;
  logic [31:0] o_sd_lba;
  logic [7:0] o_sd_cmd, sd_status, sd_wdata, o_sd_buf_rdata;
  logic [8:0] sd_addr;
  sd_multi_sector_buffer #(.SECTOR_AW(9), .NUM_BUF(4), .ADDR_W(12)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .o_irq(o_irq), .o_busy(o_busy),
    .o_sd_lba(o_sd_lba), .o_sd_cmd(o_sd_cmd), .i_sd_cmd_done(sd_done), .i_sd_status(sd_status),
    .i_sd_buf_addr(sd_addr), .i_sd_buf_wr(sd_wr), .i_sd_buf_wdata(sd_wdata),
    .o_sd_buf_rdata(o_sd_buf_rdata));
  int vecs = 0;
  int fails = 0;
  typedef struct {bit chk; logic [7:0] val; string nm;} exp_t;
  exp_t sb[$];
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.data_dv) begin
      if (sb.size() == 0) begin
        vecs++;
        fails++;
        $display("FAIL unexpected_ack: got data_dv=1 want 0");
      end else begin
        e = sb.pop_front();
        if (e.chk) begin
          vecs++;
          if (bus.rdata !== e.val) begin
            fails++;
            $display("FAIL %s: got %h want %h", e.nm, bus.rdata, e.val);
          end
        end
      end
    end
  end
  task automatic cpu(bit w, logic [11:0] a, logic [7:0] d, bit chk, string nm);
    @(negedge clk);
    bus.request = 1'b1;
    bus.write = w;
    bus.address = a;
    bus.wdata = d;
    sb.push_back('{chk, d, nm});
    @(negedge clk);
    bus.request = 1'b0;
    bus.write = 1'b0;
  endtask
  task automatic wr(logic [11:0] a, logic [7:0] d);
    cpu(1'b1, a, d, 1'b0, "wr");
  endtask
  task automatic rd(logic [11:0] a, logic [7:0] exp, string nm);
    cpu(1'b0, a, exp, 1'b1, nm);
  endtask
  task automatic set_xfer(logic [31:0] lba, logic [7:0] cnt, logic [7:0] fb);
    for (int i = 0; i < 4; i++) wr(12'(R + i), lba[8*i +: 8]);
    wr(12'(R + 5), cnt);
    wr(12'(R + 7), fb);
  endtask
  // controller model: waits for a command, moves one sector, then pulses done
  task automatic serve(logic [7:0] cmd, logic [31:0] lba, logic [7:0] st);
    int n = 0;
    int bad = 0;
    int held = 0;
    @(negedge clk);
    while (o_sd_cmd == 8'h00 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("sd_cmd", o_sd_cmd, cmd);
    check("sd_lba", o_sd_lba, lba);
    check("busy_in_xfer", o_busy, 1);
    for (int i = 0; i <= 512; i++) begin
      if (cmd == 8'h02 && i > 0 && o_sd_buf_rdata !== 8'(i - 1)) bad++;
      if (o_sd_cmd !== cmd) held++;
      if (i < 512) begin
        sd_addr = 9'(i);
        sd_wr = (cmd == 8'h01);
        sd_wdata = lba[7:0] ^ 8'(i);
      end else sd_wr = 1'b0;
      @(negedge clk);
    end
    if (cmd == 8'h02) check("sd_wr_pattern_bad_bytes", bad, 0);
    check("cmd_held_bad_cycles", held, 0);
    sd_done = 1'b1;
    sd_status = st;
    @(negedge clk);
    sd_done = 1'b0;
    sd_status = 8'h00;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.request = 1'b0;
    bus.write = 1'b0;
    bus.address = '0;
    bus.wdata = '0;
    sd_done = 1'b0;
    sd_status = 8'h00;
    sd_wr = 1'b0;
    sd_addr = '0;
    sd_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd", o_sd_cmd, 0);
    check("rst_busy", o_busy, 0);
    check("rst_irq", o_irq, 0);
    check("rst_dv", bus.data_dv, 0);
    rst_n = 1'b1;
    rd(12'(R + 6), 8'h00, "rst_status");
    rd(12'(R + 7), 8'h00, "rst_first_buf");
    set_xfer(32'h100, 8'd3, 8'd2);
    wr(12'(R + 4), 8'h01);
    for (int s = 0; s < 3; s++) serve(8'h01, 32'h100 + s, 8'h00);
    check("read_idle_cmd", o_sd_cmd, 0);
    rd(12'(R + 6), 8'h02, "read_status_done");
    for (int s = 0; s < 3; s++) begin
      rd(12'(((2 + s) % 4) * 512 + 0), 8'(s) ^ 8'h00, "read_buf_b0");
      rd(12'(((2 + s) % 4) * 512 + 1), 8'(s) ^ 8'h01, "read_buf_b1");
      rd(12'(((2 + s) % 4) * 512 + 255), 8'(s) ^ 8'hff, "read_buf_b255");
      rd(12'(((2 + s) % 4) * 512 + 511), 8'(s) ^ 8'hff, "read_buf_b511");
    end
    rd(12'(R + 1), 8'h01, "lba_reg_unchanged");
    rd(12'(R + 0), 8'h00, "lba_reg_b0");
    for (int i = 0; i < 512; i++) wr(12'(512 + i), 8'(i));
    rd(12'(512 + 300), 8'(300), "preload_b300");
    set_xfer(32'hA5, 8'd1, 8'd1);
    wr(12'(R + 4), 8'h02);
    serve(8'h02, 32'hA5, 8'h00);
    rd(12'(R + 6), 8'h02, "write_status_done");
    set_xfer(32'h200, 8'd4, 8'd0);
    wr(12'(R + 4), 8'h01);
    serve(8'h01, 32'h200, 8'h00);
    serve(8'h01, 32'h201, 8'h04);
    repeat (3) @(negedge clk);
    check("err_no_third_cmd", o_sd_cmd, 0);
    check("err_busy", o_busy, 0);
    rd(12'(R + 6), 8'h06, "err_status");
    wr(12'(R + 6), 8'h02);
    rd(12'(R + 6), 8'h00, "err_w1c_status");
    set_xfer(32'h400, 8'd5, 8'd0);
    wr(12'(R + 4), 8'h01);
    check("cnt5_busy", o_busy, 0);
    check("cnt5_cmd", o_sd_cmd, 0);
    rd(12'(R + 6), 8'h06, "cnt5_status");
    wr(12'(R + 4), 8'h03);
    check("ctl3_cmd", o_sd_cmd, 0);
    rd(12'(R + 6), 8'h06, "ctl3_status");
    wr(12'(R + 6), 8'h02);
    wr(12'(R + 6), 8'h08);
    set_xfer(32'h300, 8'd0, 8'd0);
    wr(12'(R + 4), 8'h01);
    serve(8'h01, 32'h300, 8'h00);
    check("irq_lags_done", o_irq, 0);
    check("irq_busy", o_busy, 0);
    @(negedge clk);
    check("irq_set", o_irq, 1);
    check("irq_one_sector", o_sd_cmd, 0);
    rd(12'(R + 6), 8'h0a, "irq_status");
    wr(12'(R + 6), 8'h0a);
    repeat (2) @(negedge clk);
    check("irq_cleared", o_irq, 0);
    rd(12'(R + 6), 8'h08, "irq_status_after_w1c");
    set_xfer(32'h500, 8'd1, 8'd0);
    wr(12'(R + 4), 8'h01);
    repeat (3) @(negedge clk);
    check("pre_rst_busy", o_busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_cmd", o_sd_cmd, 0);
    check("midrst_busy", o_busy, 0);
    rst_n = 1'b1;
    rd(12'(R + 6), 8'h00, "midrst_status");
    rd(12'(R + 1), 8'h00, "midrst_lba");
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
